// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary converter pipeline.
// - MODE_G2B / MODE_B2G: per-word conversion direction carried with the data.
// - gray2bin / bin2gray: conversions on a MAX_W-bit container. Callers zero-extend
//   narrower words and keep the low bits; zero-extension does not disturb the
//   low bits of either conversion, so the functions serve any width up to MAX_W.
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    localparam int unsigned MAX_W = 64;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline slot: valid bit, mode and data word.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   load_en         slot may take the upstream contents this cycle (it is empty
//                   or its own contents move on in the same cycle)
//   up_valid/mode/data  contents offered by the previous slot or the input
//   valid/mode/data     registered contents of this slot
module gray_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             up_valid,
    input  logic             up_mode,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic             mode,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else if (load_en) begin
            valid_q <= up_valid;
            // Payload only changes when a real word arrives; bubbles keep old data.
            if (up_valid) begin
                mode_q <= up_mode;
                data_q <= up_data;
            end
        end
    end

    assign valid = valid_q;
    assign mode  = mode_q;
    assign data  = data_q;

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray <-> binary converter with valid/ready on both sides.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               input handshake (in_ready 0 during reset)
//   in_mode, in_data                direction (0 = Gray->bin, 1 = bin->Gray) and word
//   out_valid/out_ready             output handshake
//   out_mode, out_data              direction and converted word, held while stalled
//   xfer_cnt                        wrapping count of output transfers
// The conversion is done in front of stage 0; PIPE register stages follow, so a
// word loaded at edge N is visible after edge N+PIPE-1.
module gray_conv_pipe
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PIPE  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [PIPE-1:0]  st_valid;
    logic [PIPE-1:0]  st_mode;
    logic [WIDTH-1:0] st_data [PIPE];
    logic [PIPE-1:0]  load_en;

    logic [MAX_W-1:0] conv_full;
    logic [WIDTH-1:0] conv_data;

    always_comb begin
        conv_full = '0;
        if (in_mode == MODE_B2G) begin
            conv_full = bin2gray(MAX_W'(in_data));
        end else begin
            conv_full = gray2bin(MAX_W'(in_data));
        end
        conv_data = conv_full[WIDTH-1:0];
    end

    if (WIDTH < MAX_W) begin : g_conv_hi
        logic unused_conv_hi;
        assign unused_conv_hi = ^conv_full[MAX_W-1:WIDTH];
    end

    // A stage may load if it, or any stage after it, is empty, or if the
    // consumer takes the last word: the whole tail then shifts by one.
    always_comb begin
        logic room;
        load_en = '0;
        room    = out_ready;
        for (int i = int'(PIPE) - 1; i >= 0; i--) begin
            room       = room | ~st_valid[i];
            load_en[i] = room;
        end
    end

    for (genvar i = 0; i < PIPE; i++) begin : g_stage
        logic             up_valid;
        logic             up_mode;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_mode  = in_mode;
            assign up_data  = conv_data;
        end else begin : g_body
            assign up_valid = st_valid[i-1];
            assign up_mode  = st_mode[i-1];
            assign up_data  = st_data[i-1];
        end

        gray_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en[i]),
            .up_valid (up_valid),
            .up_mode  (up_mode),
            .up_data  (up_data),
            .valid    (st_valid[i]),
            .mode     (st_mode[i]),
            .data     (st_data[i])
        );
    end

    assign in_ready  = rst_n & load_en[0];
    assign out_valid = st_valid[PIPE-1];
    assign out_mode  = st_mode[PIPE-1];
    assign out_data  = st_data[PIPE-1];

    logic [CNT_W-1:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed and table-driven bench for gray_conv_pipe.
// dut_a: WIDTH=4, PIPE=2, CNT_W=4. dut_b: WIDTH=8, PIPE=3, CNT_W=16.
module tb_gray_conv_pipe;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a
    logic       a_rst_n = 1'b0, a_in_valid = 1'b0, a_in_mode = 1'b0, a_out_ready = 1'b0;
    logic [3:0] a_in_data = '0;
    logic       a_in_ready, a_out_valid, a_out_mode;
    logic [3:0] a_out_data, a_xfer_cnt;

    // dut_b
    logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_in_mode = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_mode;
    logic [7:0]  b_out_data;
    logic [15:0] b_xfer_cnt;

    gray_conv_pipe #(.WIDTH(4), .PIPE(2), .CNT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_mode   (a_in_mode),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_mode  (a_out_mode),
        .out_data  (a_out_data),
        .xfer_cnt  (a_xfer_cnt)
    );

    gray_conv_pipe #(.WIDTH(8), .PIPE(3), .CNT_W(16)) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_mode   (b_in_mode),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_mode  (b_out_mode),
        .out_data  (b_out_data),
        .xfer_cnt  (b_xfer_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [8:0] b_ref(input logic m, input logic [7:0] d);
        logic [63:0] r;
        r = (m == MODE_B2G) ? bin2gray(64'(d)) : gray2bin(64'(d));
        return {m, r[7:0]};
    endfunction

    // Scoreboard for dut_b: accepted words in, converted words out, in order.
    logic [8:0] sb[$];
    int         b_out_seen  = 0;
    logic       b_hold_pend = 1'b0;
    logic [8:0] b_hold_val  = '0;

    always @(negedge clk) begin
        if (b_rst_n) begin
            if (b_hold_pend)
                check("b_hold", {b_out_valid, b_out_mode, b_out_data}, {1'b1, b_hold_val});
            b_hold_pend = b_out_valid && !b_out_ready;
            b_hold_val  = {b_out_mode, b_out_data};
            if (b_out_valid && b_out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_spurious: got word %0h expected no word",
                             {b_out_mode, b_out_data});
                end else begin
                    check("b_word", {b_out_mode, b_out_data}, sb.pop_front());
                end
                b_out_seen++;
            end
            if (b_in_valid && b_in_ready) sb.push_back(b_ref(b_in_mode, b_in_data));
        end
    end

    task automatic wait_b_drain();
        int c = 0;
        b_out_ready = 1'b1;
        while (sb.size() != 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        check("b_drain", 64'(sb.size()), 0);
    endtask

    task automatic send_b(input logic m, input logic [7:0] d, output logic [8:0] got,
                          output int lat);
        int k;
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_mode   = m;
        b_in_data   = d;
        k = 0;
        @(negedge clk);
        while (!b_in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = -1;
        got = '0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_out_valid) begin
                lat = k;
                got = {b_out_mode, b_out_data};
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        a_rst_n     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
    endtask

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] bp_in  [5];
    logic [3:0] bp_out [5];

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] got;
        int         lat;
        int         k;
        int         cyc;
        int         stall;
        int         seen0;
        bit         acc;

        tbl[0] = '{MODE_G2B, 8'hFF, 8'hAA};
        tbl[1] = '{MODE_B2G, 8'hAA, 8'hFF};
        tbl[2] = '{MODE_G2B, 8'h00, 8'h00};
        tbl[3] = '{MODE_G2B, 8'h80, 8'hFF};
        tbl[4] = '{MODE_B2G, 8'hFF, 8'h80};
        tbl[5] = '{MODE_B2G, 8'h80, 8'hC0};
        tbl[6] = '{MODE_G2B, 8'h0F, 8'h0A};
        tbl[7] = '{MODE_B2G, 8'h01, 8'h01};
        // Gray codes of 1..5 and their binary values
        bp_in[0] = 4'b0001; bp_in[1] = 4'b0011; bp_in[2] = 4'b0010;
        bp_in[3] = 4'b0110; bp_in[4] = 4'b0111;
        for (int i = 0; i < 5; i++) bp_out[i] = 4'(i + 1);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("a_rst_in_ready", a_in_ready, 0);
        check("b_rst_in_ready", b_in_ready, 0);
        check("a_rst_out_valid", a_out_valid, 0);
        check("b_rst_out_valid", b_out_valid, 0);
        check("a_rst_out_data", a_out_data, 0);
        check("b_rst_xfer_cnt", b_xfer_cnt, 0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // ---------------- dut_a: two words back to back ----------------
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_mode   = MODE_G2B;
        a_in_data   = 4'b0110;
        @(negedge clk);
        check("a_t1_ready0", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_mode = MODE_B2G;
        a_in_data = 4'b1011;
        @(negedge clk);
        check("a_t1_not_early", a_out_valid, 0);
        check("a_t1_ready1", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_t1_w0", {a_out_valid, a_out_mode, a_out_data}, {1'b1, 1'b0, 4'b0100});
        @(posedge clk);
        @(negedge clk);
        check("a_t1_w1", {a_out_valid, a_out_mode, a_out_data}, {1'b1, 1'b1, 4'b1110});
        @(posedge clk);
        @(negedge clk);
        check("a_t1_empty", a_out_valid, 0);
        check("a_t1_cnt", a_xfer_cnt, 2);

        // ---------------- dut_b: table vectors, one word at a time ----------------
        for (int i = 0; i < 8; i++) begin
            send_b(tbl[i].mode, tbl[i].din, got, lat);
            check("b_tbl_word", got, {tbl[i].mode, tbl[i].dout});
            check("b_tbl_latency", 64'(lat), 2);
        end

        // ---------------- dut_b: all codes, both modes, 1 word/cycle ----------------
        wait_b_drain();
        seen0 = b_out_seen;
        stall = 0;
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                @(posedge clk); #1;
                b_out_ready = 1'b1;
                b_in_valid  = 1'b1;
                b_in_mode   = m[0];
                b_in_data   = v[7:0];
                @(negedge clk);
                if (!b_in_ready) stall++;
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        wait_b_drain();
        check("b_full_rate_stalls", 64'(stall), 0);
        check("b_full_rate_count", 64'(b_out_seen - seen0), 512);

        // ---------------- dut_b: random valid/ready, 1000 words ----------------
        k   = 0;
        cyc = 0;
        acc = 1'b0;
        while (k < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                b_in_valid = 1'b0;
            end
            if (!b_in_valid && k < 1000 && $urandom_range(0, 3) != 0) begin
                b_in_valid = 1'b1;
                b_in_mode  = 1'($urandom_range(0, 1));
                b_in_data  = 8'($urandom_range(0, 255));
            end
            b_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
        end
        check("b_rand_sent", 64'(k), 1000);
        wait_b_drain();
        check("b_xfer_cnt", b_xfer_cnt, 16'(b_out_seen));

        // ---------------- dut_a: backpressure ----------------
        reset_a();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_mode  = MODE_G2B;
            a_in_data  = bp_in[k];
            @(negedge clk);
            if (c >= 2)
                check("a_bp_hold", {a_out_valid, a_out_mode, a_out_data}, {2'b10, bp_out[0]});
            if (a_in_ready) k++;
        end
        check("a_bp_accepted", 64'(k), 2);
        check("a_bp_in_ready", a_in_ready, 0);
        lat = 0;
        cyc = 0;
        while (lat < 5 && cyc < 50) begin
            @(posedge clk); #1;
            a_out_ready = 1'b1;
            a_in_valid  = (k < 5);
            if (k < 5) a_in_data = bp_in[k];
            @(negedge clk);
            if (a_out_valid) begin
                check("a_bp_drain", a_out_data, bp_out[lat]);
                lat++;
            end
            if (a_in_valid && a_in_ready) k++;
            cyc++;
        end
        check("a_bp_drained", 64'(lat), 5);
        @(posedge clk); #1;
        a_in_valid = 1'b0;

        // ---------------- dut_a: counter wrap at CNT_W=4 ----------------
        reset_a();
        a_out_ready = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 17 && cyc < 100) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_mode  = MODE_B2G;
            a_in_data  = k[3:0];
            @(negedge clk);
            if (a_in_ready) k++;
            cyc++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("a_wrap_accepted", 64'(k), 17);
        check("a_wrap_cnt", a_xfer_cnt, 1);

        // ---------------- dut_a: reset with two words in flight ----------------
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = MODE_B2G;
        a_in_data   = 4'b0011;
        @(negedge clk);
        @(posedge clk); #1;
        a_in_data = 4'b1000;
        @(negedge clk);
        @(posedge clk); #1;
        a_rst_n = 1'b0;
        @(negedge clk);
        check("a_rst_full_before", a_out_valid, 1);
        check("a_rst_ready_held", a_in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("a_rst_out_valid2", a_out_valid, 0);
        check("a_rst_cnt2", a_xfer_cnt, 0);
        check("a_rst_data2", {a_out_mode, a_out_data}, 0);
        check("a_rst_ready2", a_in_ready, 0);
        @(posedge clk); #1;
        a_rst_n     = 1'b1;
        a_out_ready = 1'b1;
        a_in_mode   = MODE_B2G;
        a_in_data   = 4'b0101;
        @(negedge clk);
        check("a_post_rst_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_post_rst_early", a_out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("a_post_rst_word", {a_out_valid, a_out_mode, a_out_data}, {2'b11, 4'b0111});
        @(posedge clk);
        @(negedge clk);
        check("a_post_rst_no_stale", a_out_valid, 0);
        check("a_post_rst_cnt", a_xfer_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
